// File: rtl/lc4_pkg.sv
// Shared LC4 writeback definitions: opcode values, instruction field positions
// and the decoded-control bundle passed from the decoder to the writeback stage.
package lc4_pkg;

  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 15;
  localparam int RD_MSB  = 14;
  localparam int RD_LSB  = 11;

  localparam logic [3:0] LINK_REG = 4'd15;

  localparam logic [4:0] OP_NOP     = 5'b00000;
  localparam logic [4:0] OP_BR_LAST = 5'b00100;
  localparam logic [4:0] OP_ADD     = 5'b00101;
  localparam logic [4:0] OP_SUB     = 5'b00110;
  localparam logic [4:0] OP_ADDI    = 5'b00111;
  localparam logic [4:0] OP_JSR     = 5'b01000;
  localparam logic [4:0] OP_ILL_A   = 5'b10001;
  localparam logic [4:0] OP_TCS     = 5'b10100;
  localparam logic [4:0] OP_TCDH    = 5'b10101;
  localparam logic [4:0] OP_ADDC    = 5'b10110;
  localparam logic [4:0] OP_FDEC    = 5'b11000;
  localparam logic [4:0] OP_FLD     = 5'b11001;
  localparam logic [4:0] OP_ILL_LO  = 5'b11010;

  typedef struct packed {
    logic writes_reg;
    logic writes_carry;
    logic writes_float;
    logic illegal;
    logic rd_override;
  } wb_dec_t;

endpackage

// File: rtl/lc4_alu_writeback_if.sv
// ALU-to-writeback and writeback-to-register-file signal bundle.
// The slave modport is the writeback stage; the master is its environment.
interface lc4_alu_writeback_if #(
  parameter int WORD_SIZE = 256,
  parameter int DADDR     = 4,
  parameter int INSN      = 19,
  parameter int CNT_W     = 32
);
  logic                 i_valid;
  logic                 o_ready;
  logic                 i_flush;
  logic [INSN:0]        i_insn;
  logic [WORD_SIZE-1:0] i_result;
  logic                 i_carry_out;
  logic [8:0]           i_float_out;
  logic                 o_carry;
  logic [8:0]           o_float;
  logic                 o_wb_valid;
  logic                 i_wb_ready;
  logic                 o_wb_we;
  logic [DADDR-1:0]     o_wb_rd;
  logic [WORD_SIZE-1:0] o_wb_data;
  logic                 o_illegal;
  logic [CNT_W-1:0]     o_retired;

  modport slave (
    input  i_valid, i_flush, i_insn, i_result, i_carry_out, i_float_out, i_wb_ready,
    output o_ready, o_carry, o_float, o_wb_valid, o_wb_we, o_wb_rd, o_wb_data,
           o_illegal, o_retired
  );

  modport master (
    output i_valid, i_flush, i_insn, i_result, i_carry_out, i_float_out, i_wb_ready,
    input  o_ready, o_carry, o_float, o_wb_valid, o_wb_we, o_wb_rd, o_wb_data,
           o_illegal, o_retired
  );
endinterface

// File: rtl/lc4_wb_decode.sv
// Opcode decoder: which architectural state an executed instruction updates.
module lc4_wb_decode
  import lc4_pkg::*;
(
  input  logic [4:0] i_opcode,
  output wb_dec_t    o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_ADDI, OP_TCS, OP_TCDH, OP_ADDC: begin
        o_dec.writes_reg   = 1'b1;
        o_dec.writes_carry = 1'b1;
      end
      OP_FDEC, OP_FLD: begin
        o_dec.writes_reg   = 1'b1;
        o_dec.writes_float = 1'b1;
      end
      OP_JSR: begin
        o_dec.writes_reg  = 1'b1;
        o_dec.rd_override = 1'b1;
      end
      OP_ILL_A: o_dec.illegal = 1'b1;
      default: begin
        // Everything from OP_ILL_LO upward is undefined; NOP/branches write nothing.
        if (i_opcode >= OP_ILL_LO)
          o_dec.illegal = 1'b1;
        else if (i_opcode > OP_BR_LAST)
          o_dec.writes_reg = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lc4_alu_writeback.sv
// Single-entry pass-through buffer between the ALU and the register file; commits
// carry/float flags on retirement and forwards the newest flag values to the ALU.
module lc4_alu_writeback
  import lc4_pkg::*;
#(
  parameter int WORD_SIZE = 256,
  parameter int DADDR     = 4,
  parameter int INSN      = 19,
  parameter int CNT_W     = 32
) (
  input logic                clk,
  input logic                rst_n,
  lc4_alu_writeback_if.slave bus
);

  wb_dec_t              w_dec;
  logic                 w_accept;
  logic                 w_retire;
  logic [4:0]           w_opcode;
  logic [DADDR-1:0]     w_rd;

  logic                 r_full;
  logic                 r_wr_reg;
  logic                 r_wr_carry;
  logic                 r_wr_float;
  logic                 r_ill_entry;
  logic [DADDR-1:0]     r_rd;
  logic [WORD_SIZE-1:0] r_data;
  logic                 r_carry;
  logic [8:0]           r_float;
  logic                 r_carry_q;
  logic [8:0]           r_float_q;
  logic                 r_illegal;
  logic [CNT_W-1:0]     r_retired;

  assign w_opcode = bus.i_insn[OPC_MSB:OPC_LSB];

  lc4_wb_decode u_decode (
    .i_opcode (w_opcode),
    .o_dec    (w_dec)
  );

  assign w_rd     = w_dec.rd_override ? DADDR'(LINK_REG) : DADDR'(bus.i_insn[RD_MSB:RD_LSB]);
  assign w_retire = r_full & bus.i_wb_ready;
  assign w_accept = bus.i_valid & bus.o_ready & ~bus.i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full      <= 1'b0;
      r_wr_reg    <= 1'b0;
      r_wr_carry  <= 1'b0;
      r_wr_float  <= 1'b0;
      r_ill_entry <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
      r_carry     <= 1'b0;
      r_float     <= '0;
      r_carry_q   <= 1'b0;
      r_float_q   <= '0;
      r_illegal   <= 1'b0;
      r_retired   <= '0;
    end else begin
      if (w_retire) begin
        if (r_wr_carry) r_carry_q <= r_carry;
        if (r_wr_float) r_float_q <= r_float;
        r_illegal <= r_illegal | r_ill_entry;
        r_retired <= r_retired + CNT_W'(1);
      end
      // A new accept on the retire cycle simply overwrites the departing entry.
      if (w_accept) begin
        r_full      <= 1'b1;
        r_wr_reg    <= w_dec.writes_reg;
        r_wr_carry  <= w_dec.writes_carry;
        r_wr_float  <= w_dec.writes_float;
        r_ill_entry <= w_dec.illegal;
        r_rd        <= w_rd;
        r_data      <= bus.i_result;
        r_carry     <= bus.i_carry_out;
        r_float     <= bus.i_float_out;
      end else if (w_retire) begin
        r_full <= 1'b0;
      end
    end
  end

  assign bus.o_ready    = ~r_full | bus.i_wb_ready;
  assign bus.o_wb_valid = r_full;
  assign bus.o_wb_we    = r_full & r_wr_reg;
  assign bus.o_wb_rd    = r_rd;
  assign bus.o_wb_data  = r_data;
  assign bus.o_illegal  = r_illegal;
  assign bus.o_retired  = r_retired;
  assign bus.o_carry    = (r_full & r_wr_carry) ? r_carry : r_carry_q;
  assign bus.o_float    = (r_full & r_wr_float) ? r_float : r_float_q;

endmodule

// File: tb/tb_lc4_alu_writeback.sv
// Bench for lc4_alu_writeback: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an architectural model.
module tb_lc4_alu_writeback;

  localparam int WORD_SIZE = 256;
  localparam int DADDR     = 4;
  localparam int INSN      = 19;
  localparam int CNT_W     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lc4_alu_writeback_if #(.WORD_SIZE(WORD_SIZE), .DADDR(DADDR), .INSN(INSN), .CNT_W(CNT_W)) bus ();

  lc4_alu_writeback #(.WORD_SIZE(WORD_SIZE), .DADDR(DADDR), .INSN(INSN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Architectural model: the one pending instruction plus committed state.
  logic                 m_full, m_we, m_wc, m_wf, m_ill, m_carry, m_cq, m_illegal;
  logic [3:0]           m_rd;
  logic [WORD_SIZE-1:0] m_data;
  logic [8:0]           m_float, m_fq;
  logic [CNT_W-1:0]     m_retired;
  logic                 m_ready, m_ret, m_acc;
  logic [4:0]           in_opc;
  logic                 in_wc, in_wf, in_ill, in_we;

  assign m_ready = !m_full || bus.i_wb_ready;
  assign m_ret   = m_full && bus.i_wb_ready;
  assign m_acc   = bus.i_valid && m_ready && !bus.i_flush;
  assign in_opc  = bus.i_insn[19:15];
  assign in_wc   = in_opc inside {5'd5, 5'd6, 5'd7, 5'd20, 5'd21, 5'd22};
  assign in_wf   = in_opc inside {5'd24, 5'd25};
  assign in_ill  = (in_opc == 5'd17) || (in_opc >= 5'd26);
  assign in_we   = !in_ill && (in_opc > 5'd4);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 0; m_we <= 0; m_wc <= 0; m_wf <= 0; m_ill <= 0; m_carry <= 0;
      m_cq <= 0; m_illegal <= 0; m_rd <= 0; m_data <= 0; m_float <= 0; m_fq <= 0;
      m_retired <= 0;
    end else begin
      if (m_ret) begin
        if (m_wc) m_cq <= m_carry;
        if (m_wf) m_fq <= m_float;
        if (m_ill) m_illegal <= 1'b1;
        m_retired <= m_retired + 1;
      end
      if (m_acc) begin
        m_full <= 1; m_we <= in_we; m_wc <= in_wc; m_wf <= in_wf; m_ill <= in_ill;
        m_rd <= (in_opc == 5'd8) ? 4'd15 : bus.i_insn[14:11];
        m_data <= bus.i_result; m_carry <= bus.i_carry_out; m_float <= bus.i_float_out;
      end else if (m_ret) begin
        m_full <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", bus.o_ready, m_ready);
      chk("wb_valid", bus.o_wb_valid, m_full);
      chk("wb_we", bus.o_wb_we, m_full && m_we);
      if (m_full) begin
        chk("wb_rd", bus.o_wb_rd, m_rd);
        chk("wb_data", bus.o_wb_data, m_data);
      end
      chk("carry", bus.o_carry, (m_full && m_wc) ? m_carry : m_cq);
      chk("float", bus.o_float, (m_full && m_wf) ? m_float : m_fq);
      chk("illegal", bus.o_illegal, m_illegal);
      chk("retired", bus.o_retired, m_retired);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] opc, input logic [3:0] rd, input logic [WORD_SIZE-1:0] res,
                       input logic co, input logic [8:0] fo);
    bus.i_valid     = 1'b1;
    bus.i_insn      = {opc, rd, 11'h0};
    bus.i_result    = res;
    bus.i_carry_out = co;
    bus.i_float_out = fo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_valid = 0; bus.i_flush = 0; bus.i_insn = '0; bus.i_result = '0;
    bus.i_carry_out = 0; bus.i_float_out = '0; bus.i_wb_ready = 1;
    tick(); tick();
    chk("rst_valid", bus.o_wb_valid, 0);
    chk("rst_carry", bus.o_carry, 0);
    chk("rst_float", bus.o_float, 0);
    chk("rst_data", bus.o_wb_data, 0);
    chk("rst_retired", bus.o_retired, 0);
    rst_n = 1;
    tick();

    // ADD, rd=3, result 5, carry 1
    drive(5'b00101, 4'd3, 256'd5, 1'b1, 9'h0);
    tick();
    bus.i_valid = 0;
    chk("add_valid", bus.o_wb_valid, 1);
    chk("add_we", bus.o_wb_we, 1);
    chk("add_rd", bus.o_wb_rd, 3);
    chk("add_data", bus.o_wb_data, 5);
    chk("add_fwd_carry", bus.o_carry, 1);
    tick();
    chk("add_retired", bus.o_retired, 1);
    chk("add_carry_q", bus.o_carry, 1);

    // ADDc with carry 0 held under a 3-cycle stall
    bus.i_wb_ready = 0;
    drive(5'b10110, 4'd2, 256'h77, 1'b0, 9'h0);
    tick();
    drive(5'b00110, 4'd1, 256'h99, 1'b1, 9'h0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", bus.o_ready, 0);
      chk("stall_data", bus.o_wb_data, 256'h77);
      chk("stall_carry", bus.o_carry, 0);
      chk("stall_retired", bus.o_retired, 1);
      tick();
    end
    bus.i_valid = 0;
    bus.i_wb_ready = 1;
    tick();
    chk("release_retired", bus.o_retired, 2);
    chk("release_valid", bus.o_wb_valid, 0);
    chk("release_carry", bus.o_carry, 0);
    tick();
    chk("release_once", bus.o_retired, 2);

    // back-to-back float writers
    drive(5'b11001, 4'd4, 256'h1, 1'b0, 9'h1F0);
    tick();
    chk("fld_float", bus.o_float, 9'h1F0);
    drive(5'b11000, 4'd5, 256'h2, 1'b0, 9'h1EF);
    tick();
    bus.i_valid = 0;
    chk("fdec_float", bus.o_float, 9'h1EF);
    tick();
    chk("float_q", bus.o_float, 9'h1EF);
    chk("float_retired", bus.o_retired, 4);

    // flushed SUB never enters
    drive(5'b00110, 4'd6, 256'h3, 1'b1, 9'h0);
    bus.i_flush = 1;
    tick();
    bus.i_valid = 0;
    bus.i_flush = 0;
    chk("flush_valid", bus.o_wb_valid, 0);
    chk("flush_carry", bus.o_carry, 0);
    chk("flush_retired", bus.o_retired, 4);

    // JSR then an undefined opcode
    drive(5'b01000, 4'd5, 256'h2A, 1'b0, 9'h0);
    tick();
    chk("jsr_rd", bus.o_wb_rd, 15);
    chk("jsr_data", bus.o_wb_data, 256'h2A);
    chk("jsr_we", bus.o_wb_we, 1);
    drive(5'b11111, 4'd7, 256'h5, 1'b1, 9'h55);
    tick();
    bus.i_valid = 0;
    chk("ill_we", bus.o_wb_we, 0);
    chk("ill_pending", bus.o_illegal, 0);
    tick();
    chk("ill_set", bus.o_illegal, 1);
    chk("ill_retired", bus.o_retired, 6);
    chk("ill_no_carry", bus.o_carry, 0);
    tick();
    chk("ill_sticky", bus.o_illegal, 1);

    // reset while an entry is stalled
    bus.i_wb_ready = 0;
    drive(5'b10110, 4'd1, 256'h10, 1'b1, 9'h0);
    tick();
    bus.i_valid = 0;
    chk("pre_rst_carry", bus.o_carry, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", bus.o_wb_valid, 0);
    chk("mid_rst_carry", bus.o_carry, 0);
    chk("mid_rst_float", bus.o_float, 0);
    chk("mid_rst_retired", bus.o_retired, 0);
    chk("mid_rst_illegal", bus.o_illegal, 0);
    tick();
    rst_n = 1;
    bus.i_wb_ready = 1;
    tick();
    chk("post_rst_carry", bus.o_carry, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.i_valid     = ($urandom_range(0, 3) != 0);
      bus.i_flush     = ($urandom_range(0, 7) == 0);
      bus.i_wb_ready  = ($urandom_range(0, 3) != 0);
      bus.i_insn      = 20'($urandom);
      bus.i_result    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.i_carry_out = 1'($urandom);
      bus.i_float_out = 9'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        #2;
        rst_n = 1;
      end
      tick();
    end
    bus.i_valid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lc4_alu_writeback.md
Name: lc4_alu_writeback

Overview:
- Stage directly downstream of the lc4 ALU. It captures each executed instruction's result, carry_out and float_out in a single-entry pipeline buffer with valid/ready handshake.
- On retirement it drives the register-file write port and commits the architectural carry flag and 9-bit float register.
- It returns the forwarded carry/float values to the ALU's carry and float inputs, so back-to-back dependent instructions see up-to-date flags.

Parameters:
- WORD_SIZE, 256, datapath width; matches the ALU.
- DADDR, 4, register-file address width.
- INSN, 19, MSB index of the instruction word.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  ALU output valid this cycle
- o_ready  out  1  stage can accept
- i_flush  in  1  discard the incoming instruction this cycle
- i_insn  in  INSN+1  instruction executed by the ALU
- i_result  in  WORD_SIZE  ALU o_result
- i_carry_out  in  1  ALU carry_out
- i_float_out  in  9  ALU float_out
- o_carry  out  1  forwarded carry, to the ALU carry input
- o_float  out  9  forwarded float, to the ALU float input
- o_wb_valid  out  1  writeback entry valid
- i_wb_ready  in  1  register file accepts the write
- o_wb_we  out  1  entry writes a register
- o_wb_rd  out  DADDR  destination register
- o_wb_data  out  WORD_SIZE  write data
- o_illegal  out  1  sticky: an undefined opcode retired
- o_retired  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, rst_n=0): buffer empty, o_wb_valid=0, carry_q=0, float_q=0, o_illegal=0, o_retired=0. Therefore o_carry=0, o_float=0, o_wb_we=0, o_wb_rd=0, o_wb_data=0. Reset mid-operation drops the held entry without committing it.
- o_ready = ~full | i_wb_ready. This is a pass-through buffer: a full buffer that retires this cycle also accepts in the same cycle.
- accept = i_valid & o_ready & ~i_flush. On accept, capture opcode=i_insn[19:15], rd=i_insn[14:11], i_result, i_carry_out, i_float_out and decoded flags, all into registers. Latency: 1 cycle from accept to o_wb_valid.
- i_flush kills only the incoming instruction. The held entry is older and is never flushed.
- retire = o_wb_valid & i_wb_ready. On retire:
  - carry_q <= held carry if the entry writes carry.
  - float_q <= held float if the entry writes float.
  - o_retired increments and wraps at 2^CNT_W.
  - o_illegal sets if the entry is illegal.
  - full clears unless a new accept happens the same cycle.
- Decode, by opcode:
  - Writes carry: 00101 ADD, 00110 SUB, 00111 ADDI, 10100 TCS, 10101 TCDH, 10110 ADDc.
  - Writes float: 11000, 11001.
  - No register write: 00000–00100 (NOP/branches).
  - JSR 01000: register write with rd forced to 4'd15 (link register).
  - Illegal: 10001 and 11010–11111. These give no register write and no flag update, but still retire and count.
  - All other defined opcodes write rd.
- o_wb_we = full & writes_reg. o_wb_rd and o_wb_data are held stable while o_wb_valid=1 and i_wb_ready=0.
- Forwarding (combinational from registers only, with no path from i_* inputs):
  - o_carry = (full & held_wr_carry) ? held_carry : carry_q
  - o_float = (full & held_wr_float) ? held_float : float_q
- Simultaneous retire and accept: the old entry commits its flags and the new entry loads. In the next cycle forwarding reflects the new entry if it writes flags, otherwise the just-committed carry_q/float_q.
- Stall (full & ~i_wb_ready): o_ready=0. An i_valid arriving during a stall is not captured, and upstream must hold it.

Decomposition:
- Shared package lc4_pkg holds:
  - 5-bit opcode constants (OP_ADD, OP_SUB, OP_ADDI, OP_TCS, OP_TCDH, OP_ADDC, OP_FDEC, OP_FLD, OP_JSR, …).
  - LINK_REG = 4'd15.
  - Field-position constants OPC_MSB/LSB and RD_MSB/LSB.
- One sub-module, lc4_wb_decode, is combinational: opcode -> {writes_reg, writes_carry, writes_float, illegal, rd_override}.

Test Plan:
- Reset, then ADD (00101) with i_result=5, i_carry_out=1, rd=3, i_wb_ready=1:
  - Next cycle: o_wb_valid=1, o_wb_we=1, o_wb_rd=3, o_wb_data=5, o_carry=1 (forwarded).
  - Cycle after: carry_q=1, o_retired=1.
- i_wb_ready=0 for 3 cycles after an ADDc entry: o_ready=0, o_wb_data held, o_carry shows the held carry. On release it retires exactly once.
- Back-to-back 11001 (float_out=9'h1F0) then 11000 (float_out=9'h1EF) with i_wb_ready=1: o_float=9'h1F0 then 9'h1EF, and final float_q=9'h1EF.
- i_valid=1 with i_flush=1 carrying SUB carry_out=1: no entry, o_wb_valid stays 0, o_carry unchanged, o_retired unchanged.
- JSR with i_result=0x2A: o_wb_rd=15, o_wb_data=0x2A. Then opcode 11111: o_wb_we=0, o_illegal=1 sticky after retire, o_retired=2.
- Assert rst_n=0 while an entry is stalled: o_wb_valid, o_carry, o_float and o_retired go to 0 immediately, and no commit occurs.
